// File: rtl/utopia_phy_tx_if.sv
// Utopia Level-1 PHY transmit bundle: cell enqueue handshake plus the byte-serial
// data/soc/clav/en bus toward the ATM-layer receive core.
interface utopia_phy_tx_if #(
  parameter int IfWidth   = 8,
  parameter int CellBytes = 53
);
  logic [CellBytes*8-1:0] cell_in;
  logic                   cell_valid;
  logic                   cell_ready;
  logic [IfWidth-1:0]     data;
  logic                   soc;
  logic                   clav;
  logic                   en;

  modport master (
    input  cell_in, cell_valid, en,
    output cell_ready, data, soc, clav
  );

  modport slave (
    output cell_in, cell_valid, en,
    input  cell_ready, data, soc, clav
  );
endinterface

// File: rtl/utopia_phy_tx.sv
// PHY-side Utopia Level-1 cell source: buffers whole cells in a small FIFO and
// streams them byte-serially under the receiver's active-low en.
module utopia_phy_tx #(
  parameter int IfWidth   = 8,
  parameter int CellBytes = 53,
  parameter int Depth     = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  utopia_phy_tx_if.master  bus,
  output logic [15:0]      cells_sent
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int IdxW = $clog2(CellBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CellBytes - 1);

  if (IfWidth != 8) begin : g_bad_width
    $error("utopia_phy_tx: IfWidth must be 8");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("utopia_phy_tx: Depth must be a power of 2 and >= 2");
  end

  typedef enum logic {IDLE, XFER} state_e;

  state_e                 state_q, state_d;
  logic [CellBytes*8-1:0] mem_q [Depth];
  logic [CellBytes*8-1:0] rd_cell;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IfWidth-1:0]     data_q, data_d;
  logic                   soc_q, soc_d, clav_q, clav_d;
  logic [15:0]            cells_sent_q, cells_sent_d;
  logic                   push, pop, start, last_byte;

  assign bus.cell_ready = count_q < CntW'(Depth);
  assign bus.data       = data_q;
  assign bus.soc        = soc_q;
  assign bus.clav       = clav_q;
  assign cells_sent     = cells_sent_q;

  assign rd_cell   = mem_q[rd_ptr_q];
  assign push      = bus.cell_valid && bus.cell_ready;
  assign start     = (state_q == IDLE) && clav_q && !bus.en;
  assign last_byte = (state_q == XFER) && !bus.en && (idx_q == LastIdx);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = XFER;
      XFER:    if (last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    soc_d        = 1'b0;
    idx_d        = idx_q;
    pop          = 1'b0;
    cells_sent_d = cells_sent_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d = rd_cell[IfWidth-1:0];
          soc_d  = 1'b1;
          idx_d  = IdxW'(1);
        end
      end
      XFER: begin
        if (!bus.en) begin
          data_d = rd_cell[IfWidth*idx_q +: IfWidth];
          idx_d  = idx_q + 1'b1;
          if (last_byte) begin
            pop          = 1'b1;
            idx_d        = '0;
            cells_sent_d = cells_sent_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    // The cell being streamed still occupies its slot until popped, so it is
    // excluded from availability using the next-cycle state.
    clav_d   = count_d > CntW'(state_d == XFER);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      soc_q        <= 1'b0;
      clav_q       <= 1'b0;
      cells_sent_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      soc_q        <= soc_d;
      clav_q       <= clav_d;
      cells_sent_q <= cells_sent_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= bus.cell_in;
  end
endmodule

// File: tb/tb_utopia_phy_tx.sv
// Bench for utopia_phy_tx: a receive-side byte collector plus a queue model of
// accepted cells; directed scenarios and a randomized traffic run.
module tb_utopia_phy_tx;
  localparam int CB = 53;
  typedef logic [CB*8-1:0] cell_t;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] cells_sent;

  utopia_phy_tx_if #(.IfWidth(8), .CellBytes(CB)) bus ();

  utopia_phy_tx #(.IfWidth(8), .CellBytes(CB), .Depth(2)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .bus        (bus),
    .cells_sent (cells_sent)
  );

  always #5 clk_in = ~clk_in;

  int         tests_run = 0;
  int         fails     = 0;
  cell_t      acc_q[$];
  cell_t      rx_cells[$];
  logic [7:0] rx_bytes[$];
  bit         rx_active = 1'b0;
  int         soc_err = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         last_soc_cyc = 0;
  logic       en_edge;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic cell_t rand_cell();
    cell_t c;
    for (int k = 0; k < CB; k++) c[k*8 +: 8] = 8'($urandom);
    return c;
  endfunction

  function automatic logic [7:0] byte_of(input cell_t c, input int k);
    return c[k*8 +: 8];
  endfunction

  function automatic int pending();
    return acc_q.size() - rx_cells.size();
  endfunction

  task automatic model_reset();
    acc_q = {};
    rx_cells = {};
    rx_bytes = {};
    rx_active = 1'b0;
  endtask

  // Advance one clock; act as the receive core collecting bytes it enabled.
  task automatic step();
    cell_t c;
    @(posedge clk_in);
    en_edge = bus.en;
    @(negedge clk_in);
    cyc++;
    if (bus.soc === 1'b1) begin
      if (rx_active) soc_err++;
      rx_bytes = {};
      rx_bytes.push_back(bus.data);
      rx_active = 1'b1;
      last_soc_cyc = cyc;
    end else if (rx_active && en_edge === 1'b0) begin
      rx_bytes.push_back(bus.data);
    end
    if (rx_active && rx_bytes.size() == CB) begin
      for (int k = 0; k < CB; k++) c[k*8 +: 8] = rx_bytes[k];
      rx_cells.push_back(c);
      rx_active = 1'b0;
      last_done_cyc = cyc;
    end
  endtask

  task automatic enqueue(input cell_t c);
    bus.cell_in = c;
    bus.cell_valid = 1'b1;
    if (pending() < 2) acc_q.push_back(c);
    step();
    bus.cell_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cell_valid = 1'b0;
    bus.cell_in = '0;
    bus.en = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
    #1;
    tests_run++; if (bus.data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.data); end
    tests_run++; if (bus.soc !== 1'b0) begin fails++; $display("FAIL reset_soc: got %b want 0", bus.soc); end
    tests_run++; if (bus.clav !== 1'b0) begin fails++; $display("FAIL reset_clav: got %b want 0", bus.clav); end
    tests_run++; if (cells_sent !== 16'h0) begin fails++; $display("FAIL reset_cells_sent: got %h want 0000", cells_sent); end
    tests_run++; if (bus.cell_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.cell_ready); end
  endtask

  task automatic test_single();
    cell_t c;
    for (int k = 0; k < CB; k++) c[k*8 +: 8] = 8'(k);
    @(negedge clk_in);
    bus.en = 1'b0;
    enqueue(c);
    tests_run++; if (bus.clav !== 1'b1) begin fails++; $display("FAIL single_clav_after_write: got %b want 1", bus.clav); end
    tests_run++; if (bus.soc !== 1'b0) begin fails++; $display("FAIL single_soc_early: got %b want 0", bus.soc); end
    step();
    tests_run++; if (bus.soc !== 1'b1) begin fails++; $display("FAIL single_soc: got %b want 1", bus.soc); end
    tests_run++; if (bus.data !== 8'h00) begin fails++; $display("FAIL single_byte0: got %h want 00", bus.data); end
    tests_run++; if (bus.clav !== 1'b0) begin fails++; $display("FAIL single_clav_drop: got %b want 0", bus.clav); end
    for (int k = 1; k < CB; k++) begin
      step();
      tests_run++;
      if (bus.data !== 8'(k) || bus.soc !== 1'b0) begin
        fails++; $display("FAIL single_byte%0d: got data=%h soc=%b want data=%h soc=0", k, bus.data, bus.soc, 8'(k));
      end
    end
    tests_run++; if (cells_sent !== 16'd1) begin fails++; $display("FAIL single_cells_sent: got %0d want 1", cells_sent); end
    tests_run++; if (bus.clav !== 1'b0) begin fails++; $display("FAIL single_clav_end: got %b want 0", bus.clav); end
    tests_run++; if (rx_cells.size() != 1 || rx_cells[0] !== c) begin fails++; $display("FAIL single_cell_content: got %0d cells want 1 matching", rx_cells.size()); end
  endtask

  task automatic test_fill();
    cell_t a, b, x;
    int a_done;
    a = rand_cell(); b = rand_cell(); x = rand_cell();
    a_done = 0;
    bus.en = 1'b1;
    tests_run++; if (bus.cell_ready !== 1'b1) begin fails++; $display("FAIL fill_ready0: got %b want 1", bus.cell_ready); end
    enqueue(a);
    tests_run++; if (bus.cell_ready !== 1'b1) begin fails++; $display("FAIL fill_ready1: got %b want 1", bus.cell_ready); end
    enqueue(b);
    tests_run++; if (bus.cell_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_full: got %b want 0", bus.cell_ready); end
    tests_run++; if (bus.clav !== 1'b1) begin fails++; $display("FAIL fill_clav: got %b want 1", bus.clav); end
    enqueue(x);
    tests_run++; if (bus.cell_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_still_full: got %b want 0", bus.cell_ready); end
    bus.en = 1'b0;
    for (int i = 0; i < 300 && rx_cells.size() < 3; i++) begin
      step();
      if (rx_cells.size() == 2 && a_done == 0) a_done = last_done_cyc;
    end
    tests_run++; if (rx_cells.size() != 3) begin fails++; $display("FAIL fill_timeout: got %0d cells want 3", rx_cells.size()); end
    tests_run++; if (last_soc_cyc - a_done != 1) begin fails++; $display("FAIL fill_gap: got %0d cycles want 1", last_soc_cyc - a_done); end
    tests_run++; if (rx_cells.size() < 3 || rx_cells[1] !== a || rx_cells[2] !== b) begin fails++; $display("FAIL fill_order: cells A,B not received in order (got %0d cells)", rx_cells.size()); end
    tests_run++; if (cells_sent !== 16'd3) begin fails++; $display("FAIL fill_cells_sent: got %0d want 3", cells_sent); end
    for (int i = 0; i < 60; i++) step();
    tests_run++; if (rx_cells.size() != 3) begin fails++; $display("FAIL fill_third_ignored: got %0d cells want 3", rx_cells.size()); end
    tests_run++; if (bus.clav !== 1'b0 || bus.cell_ready !== 1'b1) begin fails++; $display("FAIL fill_drained: got clav=%b ready=%b want 0,1", bus.clav, bus.cell_ready); end
  endtask

  task automatic test_pause();
    cell_t c;
    c = rand_cell();
    bus.en = 1'b0;
    enqueue(c);
    for (int i = 0; i < 100 && !(rx_active && rx_bytes.size() == 11); i++) step();
    tests_run++; if (!(rx_active && rx_bytes.size() == 11)) begin fails++; $display("FAIL pause_reach_byte10: got %0d bytes want 11", rx_bytes.size()); end
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.data !== byte_of(c, 10) || bus.soc !== 1'b0) begin
        fails++; $display("FAIL pause_hold%0d: got data=%h soc=%b want data=%h soc=0", i, bus.data, bus.soc, byte_of(c, 10));
      end
    end
    bus.en = 1'b0;
    step();
    tests_run++; if (bus.data !== byte_of(c, 11)) begin fails++; $display("FAIL pause_resume: got %h want %h", bus.data, byte_of(c, 11)); end
    for (int i = 0; i < 100 && rx_cells.size() < 4; i++) step();
    tests_run++; if (rx_cells.size() != 4 || rx_cells[3] !== c) begin fails++; $display("FAIL pause_cell_content: got %0d cells want 4 with matching last", rx_cells.size()); end
    tests_run++; if (cells_sent !== 16'd4) begin fails++; $display("FAIL pause_cells_sent: got %0d want 4", cells_sent); end
  endtask

  task automatic test_reset_mid();
    cell_t c, f;
    int socs;
    c = rand_cell(); f = rand_cell();
    bus.en = 1'b0;
    enqueue(c);
    for (int i = 0; i < 100 && !(rx_active && rx_bytes.size() == 31); i++) step();
    tests_run++; if (!(rx_active && rx_bytes.size() == 31)) begin fails++; $display("FAIL rstmid_reach_byte30: got %0d bytes want 31", rx_bytes.size()); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.soc !== 1'b0 || bus.clav !== 1'b0 || bus.data !== 8'h00 || cells_sent !== 16'h0 || bus.cell_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_outputs: got soc=%b clav=%b data=%h sent=%h ready=%b want 0,0,00,0000,1",
                        bus.soc, bus.clav, bus.data, cells_sent, bus.cell_ready);
    end
    model_reset();
    step();
    step();
    reset = 1'b0;
    socs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.soc !== 1'b0 || rx_bytes.size() != 0) socs++;
    end
    tests_run++; if (socs != 0) begin fails++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", socs); end
    enqueue(f);
    step();
    tests_run++; if (bus.soc !== 1'b1 || bus.data !== byte_of(f, 0)) begin fails++; $display("FAIL rstmid_fresh_soc: got soc=%b data=%h want 1,%h", bus.soc, bus.data, byte_of(f, 0)); end
    for (int i = 0; i < 100 && rx_cells.size() < 1; i++) step();
    tests_run++; if (rx_cells.size() != 1 || rx_cells[0] !== f) begin fails++; $display("FAIL rstmid_fresh_cell: got %0d cells want 1 matching", rx_cells.size()); end
    tests_run++; if (cells_sent !== 16'd1) begin fails++; $display("FAIL rstmid_cells_sent: got %0d want 1", cells_sent); end
  endtask

  task automatic test_empty();
    test_reset();
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (bus.clav !== 1'b0 || bus.soc !== 1'b0 || bus.data !== 8'h00 || cells_sent !== 16'h0) begin
        fails++; $display("FAIL empty_cycle%0d: got clav=%b soc=%b data=%h sent=%h want 0,0,00,0000",
                          i, bus.clav, bus.soc, bus.data, cells_sent);
      end
    end
  endtask

  task automatic test_wrap();
    cell_t c;
    c = rand_cell();
    bus.en = 1'b1;
    force dut.cells_sent_q = 16'hFFFF;
    step();
    release dut.cells_sent_q;
    bus.en = 1'b0;
    enqueue(c);
    for (int i = 0; i < 100 && rx_cells.size() < 1; i++) step();
    tests_run++; if (rx_cells.size() != 1 || rx_cells[0] !== c) begin fails++; $display("FAIL wrap_cell: got %0d cells want 1 matching", rx_cells.size()); end
    tests_run++; if (cells_sent !== 16'h0000) begin fails++; $display("FAIL wrap_cells_sent: got %h want 0000", cells_sent); end
  endtask

  task automatic test_random();
    cell_t c;
    int    n_push;
    logic  exp_ready, exp_clav;
    test_reset();
    n_push = 0;
    for (int cy = 0; cy < 4000 && !(n_push >= 12 && pending() == 0); cy++) begin
      exp_ready = (pending() < 2);
      exp_clav  = ((pending() - int'(rx_active)) > 0);
      tests_run++; if (bus.cell_ready !== exp_ready) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", cy, bus.cell_ready, exp_ready); end
      tests_run++; if (bus.clav !== exp_clav) begin fails++; $display("FAIL rand_clav@%0d: got %b want %b", cy, bus.clav, exp_clav); end
      if (n_push < 12 && $urandom_range(0, 2) == 0) begin
        c = rand_cell();
        bus.cell_in = c;
        bus.cell_valid = 1'b1;
        if (exp_ready) begin acc_q.push_back(c); n_push++; end
      end else begin
        bus.cell_valid = 1'b0;
      end
      bus.en = ($urandom_range(0, 9) < 3);
      step();
    end
    bus.cell_valid = 1'b0;
    tests_run++; if (n_push != 12 || pending() != 0) begin fails++; $display("FAIL rand_timeout: got %0d pushed %0d pending want 12,0", n_push, pending()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      tests_run++;
      if (i >= rx_cells.size() || rx_cells[i] !== acc_q[i]) begin fails++; $display("FAIL rand_cell%0d: received cell differs from enqueued", i); end
    end
    tests_run++; if (cells_sent !== 16'd12) begin fails++; $display("FAIL rand_cells_sent: got %0d want 12", cells_sent); end
    tests_run++; if (soc_err != 0) begin fails++; $display("FAIL rand_soc_midcell: got %0d want 0", soc_err); end
  endtask

  initial begin
    bus.cell_valid = 1'b0;
    bus.cell_in = '0;
    bus.en = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_pause();
    test_reset_mid();
    test_empty();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
